// File: rtl/eth_tx_arbiter.sv
// Ethernet transmit arbiter: shares one GMII transmit path between an ARP
// engine and a UDP engine. Pending requests are sticky bits. The ARP class
// (reply beats request) and the UDP class alternate round-robin, and a busy
// grant that never sees its done pulse is abandoned after TIMEOUT_CYCLES.
// Build option: define ETH_ARB_IFG_EN to hold the GAP state for IFG_CYCLES
// idle cycles after every frame. Left undefined, the GAP state does not
// exist and a finished frame returns straight to IDLE.
module eth_tx_arbiter #(
    parameter int IFG_CYCLES     = 12,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arp_rx_done,
    input  logic       arp_rx_type,
    input  logic       arp_req,
    input  logic       arp_tx_done,
    input  logic       arp_gmii_tx_en,
    input  logic [7:0] arp_gmii_txd,
    input  logic       udp_tx_req,
    input  logic       udp_tx_done,
    input  logic       udp_gmii_tx_en,
    input  logic [7:0] udp_gmii_txd,
    output logic       arp_tx_en,
    output logic       arp_tx_type,
    output logic       udp_tx_start_en,
    output logic       udp_tx_busy,
    output logic       gmii_tx_en,
    output logic [7:0] gmii_txd,
    output logic       timeout_err
);

    // Parameter sanity check at elaboration; the timeout counter is 16 bits.
    if (IFG_CYCLES < 1 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_params
        $error("eth_tx_arbiter: IFG_CYCLES must be >= 1, TIMEOUT_CYCLES in 2..65536");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARP_BUSY = 2'd1,
        UDP_BUSY = 2'd2
`ifdef ETH_ARB_IFG_EN
        ,
        GAP      = 2'd3
`endif
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        rply_q, rply_d;       // ARP reply owed (request received)
    logic        areq_q, areq_d;       // user ARP request
    logic        udp_q, udp_d;         // user UDP request
    logic        rr_udp_q, rr_udp_d;   // UDP class has priority at next contended grant
    logic        first_q, first_d;     // current cycle is the first busy cycle
    logic        type_q, type_d;       // ARP type latched at grant
    logic [15:0] to_cnt_q, to_cnt_d;   // busy-cycle counter
    logic        timeout_q, timeout_d;

`ifdef ETH_ARB_IFG_EN
    localparam int IFG_W = $clog2(IFG_CYCLES + 1);
    localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_CYCLES - 1);
    logic [IFG_W-1:0] ifg_cnt_q, ifg_cnt_d;
`endif

    logic busy;
    logic done_hit;
    logic to_hit;
    logic clr_rply, clr_areq, clr_udp;

    // Next-state, grant and pending-bit logic.
    always_comb begin
        state_d   = state_q;
        rr_udp_d  = rr_udp_q;
        first_d   = 1'b0;
        type_d    = type_q;
        to_cnt_d  = '0;
        timeout_d = 1'b0;
        clr_rply  = 1'b0;
        clr_areq  = 1'b0;
        clr_udp   = 1'b0;
`ifdef ETH_ARB_IFG_EN
        ifg_cnt_d = '0;
`endif

        busy     = (state_q == ARP_BUSY) || (state_q == UDP_BUSY);
        // Done is meaningless in the start cycle and from the other engine.
        done_hit = !first_q && (((state_q == ARP_BUSY) && arp_tx_done) ||
                                ((state_q == UDP_BUSY) && udp_tx_done));
        to_hit   = busy && !done_hit && (to_cnt_q == TO_LAST);

        // The served bit drops in the start cycle; a request in that cycle re-arms it.
        if (first_q) begin
            if (state_q == ARP_BUSY) begin
                clr_rply = type_q;
                clr_areq = !type_q;
            end
            if (state_q == UDP_BUSY) begin
                clr_udp = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if ((rply_q || areq_q) && (!udp_q || !rr_udp_q)) begin
                    state_d  = ARP_BUSY;
                    first_d  = 1'b1;
                    type_d   = rply_q;
                    rr_udp_d = 1'b1;
                end else if (udp_q) begin
                    state_d  = UDP_BUSY;
                    first_d  = 1'b1;
                    rr_udp_d = 1'b0;
                end
            end
            ARP_BUSY, UDP_BUSY: begin
                if (done_hit || to_hit) begin
`ifdef ETH_ARB_IFG_EN
                    state_d = GAP;
`else
                    state_d = IDLE;
`endif
                    type_d    = 1'b0;
                    timeout_d = to_hit;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
            end
`ifdef ETH_ARB_IFG_EN
            GAP: begin
                if (ifg_cnt_q == IFG_LAST) begin
                    state_d = IDLE;
                end else begin
                    ifg_cnt_d = ifg_cnt_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                type_d  = 1'b0;
            end
        endcase

        rply_d = (rply_q && !clr_rply) || (arp_rx_done && !arp_rx_type);
        areq_d = (areq_q && !clr_areq) || arp_req;
        udp_d  = (udp_q && !clr_udp) || udp_tx_req;
    end

    // State and pending registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rply_q    <= 1'b0;
            areq_q    <= 1'b0;
            udp_q     <= 1'b0;
            rr_udp_q  <= 1'b0;
            first_q   <= 1'b0;
            type_q    <= 1'b0;
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
`ifdef ETH_ARB_IFG_EN
            ifg_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rply_q    <= rply_d;
            areq_q    <= areq_d;
            udp_q     <= udp_d;
            rr_udp_q  <= rr_udp_d;
            first_q   <= first_d;
            type_q    <= type_d;
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
`ifdef ETH_ARB_IFG_EN
            ifg_cnt_q <= ifg_cnt_d;
`endif
        end
    end

    // Status outputs and zero-latency GMII mux.
    always_comb begin
        arp_tx_en       = (state_q == ARP_BUSY) && first_q;
        udp_tx_start_en = (state_q == UDP_BUSY) && first_q;
        arp_tx_type     = type_q;
        udp_tx_busy     = udp_q || (state_q == UDP_BUSY);
        timeout_err     = timeout_q;
        gmii_tx_en      = 1'b0;
        gmii_txd        = 8'h00;
        if (state_q == ARP_BUSY) begin
            gmii_tx_en = arp_gmii_tx_en;
            gmii_txd   = arp_gmii_txd;
        end else if (state_q == UDP_BUSY) begin
            gmii_tx_en = udp_gmii_tx_en;
            gmii_txd   = udp_gmii_txd;
        end
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter: directed scenarios push expected start
// and timeout events (with hand-computed cycle numbers); a monitor pops and
// compares whenever the DUT pulses a start or timeout output.
module tb_eth_tx_arbiter;

`ifdef ETH_ARB_IFG_EN
    localparam int G = 12;
`else
    localparam int G = 0;
`endif

    localparam int K_ARP = 0;
    localparam int K_UDP = 1;
    localparam int K_TO  = 2;

    typedef struct {
        int         kind;
        int         cyc;
        logic       typ;
        logic [7:0] data;
        logic       en;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc   = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       arp_rx_done = 1'b0;
    logic       arp_rx_type = 1'b0;
    logic       arp_req = 1'b0;
    logic       udp_tx_req = 1'b0;
    logic       inj_arp_done = 1'b0;
    logic       inj_udp_done = 1'b0;
    logic       arp_done_eng = 1'b0;
    logic       udp_done_eng = 1'b0;
    logic       udp_hang = 1'b0;
    logic       arp_gmii_tx_en = 1'b0;
    logic [7:0] arp_gmii_txd = 8'hD5;
    logic       udp_gmii_tx_en = 1'b0;
    logic [7:0] udp_gmii_txd = 8'h55;
    wire        arp_tx_done = arp_done_eng | inj_arp_done;
    wire        udp_tx_done = udp_done_eng | inj_udp_done;
    logic       arp_tx_en, arp_tx_type, udp_tx_start_en, udp_tx_busy;
    logic       gmii_tx_en, timeout_err;
    logic [7:0] gmii_txd;

    eth_tx_arbiter #(.IFG_CYCLES(12), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .arp_rx_done(arp_rx_done), .arp_rx_type(arp_rx_type), .arp_req(arp_req),
        .arp_tx_done(arp_tx_done), .arp_gmii_tx_en(arp_gmii_tx_en), .arp_gmii_txd(arp_gmii_txd),
        .udp_tx_req(udp_tx_req), .udp_tx_done(udp_tx_done),
        .udp_gmii_tx_en(udp_gmii_tx_en), .udp_gmii_txd(udp_gmii_txd),
        .arp_tx_en(arp_tx_en), .arp_tx_type(arp_tx_type),
        .udp_tx_start_en(udp_tx_start_en), .udp_tx_busy(udp_tx_busy),
        .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ev(input int kind, input int c, input logic typ,
                             input logic [7:0] data, input logic en);
        ev_t e;
        e.kind = kind; e.cyc = c; e.typ = typ; e.data = data; e.en = en;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ARP engine model: 4 data cycles starting in the start cycle, then done.
    always begin
        @(posedge clk);
        #1;
        if (arp_tx_en === 1'b1) begin
            for (int k = 0; k < 4; k++) begin
                arp_gmii_tx_en = 1'b1;
                arp_gmii_txd   = (k == 0) ? 8'hD5 : 8'(8'h20 + k);
                @(posedge clk);
                #1;
            end
            arp_gmii_tx_en = 1'b0;
            arp_gmii_txd   = 8'hD5;
            arp_done_eng   = 1'b1;
            @(posedge clk);
            #1;
            arp_done_eng = 1'b0;
        end
    end

    // UDP engine model; with udp_hang set it keeps tx_en high and never finishes.
    always begin
        @(posedge clk);
        #1;
        if (udp_tx_start_en === 1'b1) begin
            for (int k = 0; k < 4; k++) begin
                udp_gmii_tx_en = 1'b1;
                udp_gmii_txd   = (k == 0) ? 8'h55 : 8'(8'h10 + k);
                @(posedge clk);
                #1;
            end
            if (udp_hang) begin
                while (udp_hang) begin
                    @(posedge clk);
                    #1;
                end
                udp_gmii_tx_en = 1'b0;
                udp_gmii_txd   = 8'h55;
            end else begin
                udp_gmii_tx_en = 1'b0;
                udp_gmii_txd   = 8'h55;
                udp_done_eng   = 1'b1;
                @(posedge clk);
                #1;
                udp_done_eng = 1'b0;
            end
        end
    end

    // Monitor: every start or timeout pulse is matched against the next expected event.
    always @(negedge clk) begin
        if (arp_tx_en === 1'b1 || udp_tx_start_en === 1'b1 || timeout_err === 1'b1) begin
            ev_t a;
            a.kind = (timeout_err === 1'b1) ? K_TO : ((arp_tx_en === 1'b1) ? K_ARP : K_UDP);
            a.cyc  = cyc;
            a.typ  = arp_tx_type;
            a.data = gmii_txd;
            a.en   = gmii_tx_en;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: got kind=%0d cyc=%0d, expected no event", a.kind, a.cyc);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (a.kind != e.kind || a.cyc != e.cyc || a.typ !== e.typ ||
                    a.data !== e.data || a.en !== e.en) begin
                    n_bad++;
                    $display("FAIL event: got kind=%0d cyc=%0d type=%b txd=%h en=%b, expected kind=%0d cyc=%0d type=%b txd=%h en=%b",
                             a.kind, a.cyc, a.typ, a.data, a.en, e.kind, e.cyc, e.typ, e.data, e.en);
                end else begin
                    $display("event ok: kind=%0d cyc=%0d type=%b txd=%h", a.kind, a.cyc, a.typ, a.data);
                end
            end
        end
    end

    initial begin
        int c;
        // Reset state
        step(3);
        @(negedge clk);
        chk("rst_arp_tx_en", {7'd0, arp_tx_en}, 8'd0);
        chk("rst_arp_tx_type", {7'd0, arp_tx_type}, 8'd0);
        chk("rst_udp_start", {7'd0, udp_tx_start_en}, 8'd0);
        chk("rst_udp_busy", {7'd0, udp_tx_busy}, 8'd0);
        chk("rst_gmii_tx_en", {7'd0, gmii_tx_en}, 8'd0);
        chk("rst_gmii_txd", gmii_txd, 8'h00);
        chk("rst_timeout", {7'd0, timeout_err}, 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(2);

        // Single UDP request: start two cycles later with preamble on the bus.
        c = cyc;
        udp_tx_req = 1'b1;
        expect_ev(K_UDP, c + 2, 1'b0, 8'h55, 1'b1);
        step(1);
        udp_tx_req = 1'b0;
        step(30);

        // A received ARP reply (type 1) must not trigger anything.
        arp_rx_done = 1'b1;
        arp_rx_type = 1'b1;
        step(1);
        arp_rx_done = 1'b0;
        arp_rx_type = 1'b0;
        step(5);

        // ARP request received together with a UDP request: ARP reply first.
        c = cyc;
        arp_rx_done = 1'b1;
        udp_tx_req  = 1'b1;
        expect_ev(K_ARP, c + 2, 1'b1, 8'hD5, 1'b1);
        expect_ev(K_UDP, c + 8 + G, 1'b0, 8'h55, 1'b1);
        step(1);
        arp_rx_done = 1'b0;
        udp_tx_req  = 1'b0;
        step(45);

        // Reply beats request; three UDP pulses during the reply merge into one.
        c = cyc;
        arp_req     = 1'b1;
        arp_rx_done = 1'b1;
        expect_ev(K_ARP, c + 2, 1'b1, 8'hD5, 1'b1);
        expect_ev(K_UDP, c + 8 + G, 1'b0, 8'h55, 1'b1);
        expect_ev(K_ARP, c + 14 + 2 * G, 1'b0, 8'hD5, 1'b1);
        step(1);
        arp_req     = 1'b0;
        arp_rx_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            udp_tx_req = 1'b1;
            step(1);
            udp_tx_req = 1'b0;
        end
        step(60);

        // Back-to-back UDP: request re-armed in the start cycle; stray dones ignored.
        c = cyc;
        udp_tx_req = 1'b1;
        expect_ev(K_UDP, c + 2, 1'b0, 8'h55, 1'b1);
        expect_ev(K_UDP, c + 8 + G, 1'b0, 8'h55, 1'b1);
        step(1);
        udp_tx_req = 1'b0;
        step(1);
        udp_tx_req   = 1'b1;
        inj_udp_done = 1'b1;
        step(1);
        udp_tx_req   = 1'b0;
        inj_udp_done = 1'b0;
        inj_arp_done = 1'b1;
        step(1);
        inj_arp_done = 1'b0;
        step(40);

        // Timeout: UDP engine never finishes.
        udp_hang = 1'b1;
        c = cyc;
        udp_tx_req = 1'b1;
        expect_ev(K_UDP, c + 2, 1'b0, 8'h55, 1'b1);
        expect_ev(K_TO, c + 18, 1'b0, 8'h00, 1'b0);
        step(1);
        udp_tx_req = 1'b0;
        step(40);
        udp_hang = 1'b0;
        step(3);
        c = cyc;
        arp_req = 1'b1;
        expect_ev(K_ARP, c + 2, 1'b0, 8'hD5, 1'b1);
        step(1);
        arp_req = 1'b0;
        step(30);

        // One-cycle reset in the middle of a UDP frame.
        c = cyc;
        udp_tx_req = 1'b1;
        expect_ev(K_UDP, c + 2, 1'b0, 8'h55, 1'b1);
        step(1);
        udp_tx_req = 1'b0;
        step(3);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_gmii_tx_en", {7'd0, gmii_tx_en}, 8'd0);
        chk("midrst_udp_busy", {7'd0, udp_tx_busy}, 8'd0);
        chk("midrst_udp_start", {7'd0, udp_tx_start_en}, 8'd0);
        chk("midrst_gmii_txd", gmii_txd, 8'h00);
        @(posedge clk);
        #1;
        step(30);

        // After reset, contended grant goes to ARP first.
        c = cyc;
        arp_req    = 1'b1;
        udp_tx_req = 1'b1;
        expect_ev(K_ARP, c + 2, 1'b0, 8'hD5, 1'b1);
        expect_ev(K_UDP, c + 8 + G, 1'b0, 8'h55, 1'b1);
        step(1);
        arp_req    = 1'b0;
        udp_tx_req = 1'b0;
        step(50);

        chk("pending_expected_events", 8'(exp_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
